// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared CPU constants for the hazard/stall unit
package hazard_stall_unit_pkg;

    localparam logic [5:0] MUL_CYCLES = 6'd4;
    localparam logic [5:0] DIV_CYCLES = 6'd32;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_LOAD_USE = 2'd1,
        CAUSE_MDU      = 2'd2,
        CAUSE_MEM_WAIT = 2'd3
    } stall_cause_t;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/hazard_stall_unit_mdu_busy_tracker.sv
// rtl/hazard_stall_unit_mdu_busy_tracker.sv - multiply/divide busy FSM with latency down-counter
module mdu_busy_tracker
    import hazard_stall_unit_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic div,
    output logic busy
);

    mdu_state_t state, state_nxt;
    logic [5:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MDU_IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter keeps running while the pipeline is frozen; the MDU is independent of it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            MDU_IDLE: begin
                if (start) begin
                    cnt_nxt   = div ? DIV_CYCLES : MUL_CYCLES;
                    state_nxt = MDU_RUN;
                end
            end
            MDU_RUN: begin
                cnt_nxt = cnt - 6'd1;
                if (cnt == 6'd1) begin
                    state_nxt = MDU_IDLE;
                end
            end
            default: begin
                state_nxt = MDU_IDLE;
                cnt_nxt   = 6'd0;
            end
        endcase
    end

    always_comb begin
        busy = (state == MDU_RUN);
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / MDU / memory-wait stall generation and stall statistic
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        id_mdu_start,
    input  logic        id_mdu_div,
    input  logic        id_read_hilo,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        stat_clr,
    output logic        is_stall,
    output logic        idex_bubble,
    output logic        pipe_freeze,
    output logic        mdu_busy,
    output logic [1:0]  stall_cause,
    output logic [15:0] stall_cycles
);

    logic load_use;
    logic mdu_hazard;
    logic mem_wait;
    logic mdu_accept;
    stall_cause_t cause;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    assign mdu_hazard = mdu_busy && (id_read_hilo || id_mdu_start);
    assign mem_wait   = mem_req && !mem_ready;

    assign is_stall    = load_use || mdu_hazard || mem_wait;
    assign pipe_freeze = mem_wait;
    // A frozen pipeline must not also squash ID/EX, or the held instruction would be lost.
    assign idex_bubble = (load_use || mdu_hazard) && !mem_wait;
    assign mdu_accept  = id_mdu_start && !is_stall;

    always_comb begin
        if (mem_wait) begin
            cause = CAUSE_MEM_WAIT;
        end else if (load_use) begin
            cause = CAUSE_LOAD_USE;
        end else if (mdu_hazard) begin
            cause = CAUSE_MDU;
        end else begin
            cause = CAUSE_NONE;
        end
    end
    assign stall_cause = cause;

    mdu_busy_tracker u_mdu_busy_tracker (
        .clk   (clk),
        .rst   (rst),
        .start (mdu_accept),
        .div   (id_mdu_div),
        .busy  (mdu_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (stat_clr) begin
            stall_cycles <= 16'd0;
        end else if (is_stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       mr;
        logic [4:0] rd;
        logic       start;
        logic       div;
        logic       hilo;
        logic       req;
        logic       rdy;
        logic       clr;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic        freeze;
        logic        busy;
        logic [1:0]  cause;
        logic [15:0] sc;
    } exp_t;

    logic        clk;
    stim_t       cur;
    stim_t       prev;
    logic        is_stall, idex_bubble, pipe_freeze, mdu_busy;
    logic [1:0]  stall_cause;
    logic [15:0] stall_cycles;

    exp_t sb[$];
    int   m_bl;
    int   m_sc;
    int   n_checks;
    int   n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_unit dut (
        .clk          (clk),
        .rst          (cur.rst),
        .id_rs        (cur.rs),
        .id_rt        (cur.rt),
        .id_use_rs    (cur.use_rs),
        .id_use_rt    (cur.use_rt),
        .ex_mem_read  (cur.mr),
        .ex_rd        (cur.rd),
        .id_mdu_start (cur.start),
        .id_mdu_div   (cur.div),
        .id_read_hilo (cur.hilo),
        .mem_req      (cur.req),
        .mem_ready    (cur.rdy),
        .stat_clr     (cur.clr),
        .is_stall     (is_stall),
        .idex_bubble  (idex_bubble),
        .pipe_freeze  (pipe_freeze),
        .mdu_busy     (mdu_busy),
        .stall_cause  (stall_cause),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic exp_t calc(input stim_t s, input int bl, input int sc);
        exp_t e;
        logic lu, mh, mw;
        lu = s.mr && (s.rd != 0) && ((s.use_rs && s.rs == s.rd) || (s.use_rt && s.rt == s.rd));
        mh = (bl > 0) && (s.hilo || s.start);
        mw = s.req && !s.rdy;
        e.stall  = lu || mh || mw;
        e.bubble = (lu || mh) && !mw;
        e.freeze = mw;
        e.busy   = (bl > 0);
        e.cause  = mw ? 2'd3 : lu ? 2'd1 : mh ? 2'd2 : 2'd0;
        e.sc     = sc[15:0];
        return e;
    endfunction

    task automatic model_edge(input stim_t s);
        exp_t e;
        if (s.rst) begin
            m_bl = 0;
            m_sc = 0;
        end else begin
            e = calc(s, m_bl, m_sc);
            if (m_bl > 0) m_bl--;
            else if (s.start && !e.stall) m_bl = s.div ? 32 : 4;
            if (s.clr) m_sc = 0;
            else if (e.stall && m_sc < 65535) m_sc++;
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        model_edge(prev);
        #1;
        cur  = s;
        prev = s;
        if (s.rst) begin
            m_bl = 0;
            m_sc = 0;
        end
        sb.push_back(calc(s, m_bl, m_sc));
        @(negedge clk);
        e = sb.pop_front();
        check("is_stall",     int'(is_stall),     int'(e.stall));
        check("idex_bubble",  int'(idex_bubble),  int'(e.bubble));
        check("pipe_freeze",  int'(pipe_freeze),  int'(e.freeze));
        check("mdu_busy",     int'(mdu_busy),     int'(e.busy));
        check("stall_cause",  int'(stall_cause),  int'(e.cause));
        check("stall_cycles", int'(stall_cycles), int'(e.sc));
    endtask

    initial begin
        stim_t s;
        n_checks = 0;
        n_errors = 0;
        m_bl = 0;
        m_sc = 0;
        cur = '0;
        cur.rst = 1'b1;
        prev = cur;

        // reset state, with a load-use pattern visible during reset
        s = '0; s.rst = 1; step(s);
        s.mr = 1; s.rd = 5'd5; s.rs = 5'd5; s.use_rs = 1; s.hilo = 1; step(s);
        s = '0; step(s);

        // load-use hit, then resolved; ex_rd=0 never stalls; rt path
        s = '0; s.mr = 1; s.rd = 5'd5; s.rs = 5'd5; s.use_rs = 1; step(s);
        s.mr = 0; step(s);
        s = '0; s.mr = 1; s.rd = 5'd0; s.rs = 5'd0; s.use_rs = 1; step(s);
        s = '0; s.mr = 1; s.rd = 5'd9; s.rt = 5'd9; s.use_rt = 1; step(s);
        s.use_rt = 0; step(s);

        // multiply: 4 busy cycles with hilo reads, 5th free
        s = '0; s.start = 1; step(s);
        s = '0; s.hilo = 1;
        for (int i = 0; i < 6; i++) step(s);

        // divide under a 10-cycle memory freeze
        s = '0; s.start = 1; s.div = 1; step(s);
        s = '0; s.req = 1; s.rdy = 0; s.hilo = 1;
        for (int i = 0; i < 10; i++) step(s);
        s = '0; s.hilo = 1;
        for (int i = 0; i < 25; i++) step(s);

        // load-use and start together: rejected, then accepted next cycle
        s = '0; s.mr = 1; s.rd = 5'd3; s.rs = 5'd3; s.use_rs = 1; s.start = 1; step(s);
        s = '0; s.start = 1; step(s);
        s = '0; s.hilo = 1;
        for (int i = 0; i < 5; i++) step(s);

        // reset mid-divide
        s = '0; s.start = 1; s.div = 1; step(s);
        s = '0; s.req = 1; s.rdy = 0;
        for (int i = 0; i < 9; i++) step(s);
        s = '0; s.rst = 1; s.hilo = 1; step(s);
        s = '0; s.hilo = 1; step(s);
        step(s);

        // randomised mix
        for (int i = 0; i < 400; i++) begin
            s = '0;
            s.rs     = 5'($urandom_range(0, 3));
            s.rt     = 5'($urandom_range(0, 3));
            s.rd     = 5'($urandom_range(0, 3));
            s.use_rs = 1'($urandom_range(0, 1));
            s.use_rt = 1'($urandom_range(0, 1));
            s.mr     = 1'($urandom_range(0, 1));
            s.start  = ($urandom_range(0, 5) == 0);
            s.div    = ($urandom_range(0, 3) == 0);
            s.hilo   = 1'($urandom_range(0, 1));
            s.req    = ($urandom_range(0, 3) == 0);
            s.rdy    = 1'($urandom_range(0, 1));
            s.clr    = ($urandom_range(0, 30) == 0);
            s.rst    = ($urandom_range(0, 80) == 0);
            step(s);
        end

        // saturation of the statistic, then clear while stalling
        s = '0; s.clr = 1; step(s);
        s = '0; s.req = 1;
        for (int i = 0; i < 70000; i++) step(s);
        s.clr = 1; step(s);
        s.clr = 0; step(s);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
